// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder: format selector,
// opcode constants and the FIFO entry payload.
package instr_encoder_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned F7_W      = 7;
    localparam int unsigned ERR_CNT_W = 16;

    localparam logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000;
    localparam logic [XLEN-1:0] ADDR_STEP = 32'd4;

    typedef enum logic [2:0] {
        INSTR_R = 3'd0,
        INSTR_I = 3'd1,
        INSTR_S = 3'd2,
        INSTR_B = 3'd3,
        INSTR_U = 3'd4,
        INSTR_J = 3'd5
    } instr_type_enum;

    localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
    localparam logic [XLEN-1:0]  NOP_WORD  = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
        logic            err;
    } fifo_entry_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and response channels of the instruction encoder.
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    instr_type_enum       in_type;
    logic [OPC_W-1:0]     in_opcode;
    logic [REG_W-1:0]     in_rd;
    logic [REG_W-1:0]     in_rs1;
    logic [REG_W-1:0]     in_rs2;
    logic [F3_W-1:0]      in_funct3;
    logic [F7_W-1:0]      in_funct7;
    logic [XLEN-1:0]      in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_instr;
    logic [XLEN-1:0]      out_addr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Places immediate bits at their instruction-word positions for each format
// and flags immediates the format cannot represent.
module instr_encoder_imm_pack
    import instr_encoder_pkg::*;
(
    input  instr_type_enum  instr_type,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] imm_bits_c,
    output logic            range_err_c,
    output logic            type_err_c
);

    logic signed [XLEN-1:0] simm;
    assign simm = $signed(imm);

    always_comb begin
        imm_bits_c  = '0;
        range_err_c = 1'b0;
        type_err_c  = 1'b0;
        case (instr_type)
            INSTR_R: ;
            INSTR_I: begin
                imm_bits_c[31:20] = imm[11:0];
                range_err_c = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            INSTR_S: begin
                imm_bits_c[31:25] = imm[11:5];
                imm_bits_c[11:7]  = imm[4:0];
                range_err_c = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            INSTR_B: begin
                imm_bits_c[31]    = imm[12];
                imm_bits_c[30:25] = imm[10:5];
                imm_bits_c[11:8]  = imm[4:1];
                imm_bits_c[7]     = imm[11];
                range_err_c = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            end
            INSTR_U: begin
                imm_bits_c[31:12] = imm[31:12];
                range_err_c = |imm[11:0];
            end
            INSTR_J: begin
                imm_bits_c[31]    = imm[20];
                imm_bits_c[30:21] = imm[10:1];
                imm_bits_c[20]    = imm[11];
                imm_bits_c[19:12] = imm[19:12];
                range_err_c = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            end
            default: type_err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction descriptions into 32-bit words, tags each with its byte
// address, and queues {instr, addr, err} in a 2-entry FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    instr_encoder_if.slave  bus
);

    logic [XLEN-1:0]      imm_bits_c;
    logic                 range_err_c;
    logic                 type_err_c;
    logic [XLEN-1:0]      field_bits_c;
    fifo_entry_t          new_entry_c;
    logic                 accept_c;
    logic                 pop_c;

    fifo_entry_t          head_q, head_d;
    fifo_entry_t          tail_q, tail_d;
    logic                 head_vld_q, head_vld_d;
    logic                 tail_vld_q, tail_vld_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    instr_encoder_imm_pack u_imm_pack (
        .instr_type  (bus.in_type),
        .imm         (bus.in_imm),
        .imm_bits_c  (imm_bits_c),
        .range_err_c (range_err_c),
        .type_err_c  (type_err_c)
    );

    // Register/opcode fields that sit alongside the immediate for each format
    always_comb begin
        field_bits_c = '0;
        case (bus.in_type)
            INSTR_R: field_bits_c = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                                     bus.in_funct3, bus.in_rd, bus.in_opcode};
            INSTR_I: field_bits_c = {12'b0, bus.in_rs1, bus.in_funct3,
                                     bus.in_rd, bus.in_opcode};
            INSTR_S,
            INSTR_B: field_bits_c = {7'b0, bus.in_rs2, bus.in_rs1,
                                     bus.in_funct3, 5'b0, bus.in_opcode};
            INSTR_U,
            INSTR_J: field_bits_c = {20'b0, bus.in_rd, bus.in_opcode};
            default: field_bits_c = '0;
        endcase
    end

    assign new_entry_c.instr = type_err_c ? NOP_WORD : (imm_bits_c | field_bits_c);
    assign new_entry_c.addr  = addr_q;
    assign new_entry_c.err   = type_err_c | range_err_c;

    assign bus.in_ready = !tail_vld_q && !restart && !reset;
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign pop_c        = head_vld_q && bus.out_ready;

    // FIFO shifts toward the head so outputs come straight from head_q
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        addr_d     = addr_q;
        err_cnt_d  = err_cnt_q;
        if (restart) begin
            head_vld_d = 1'b0;
            tail_vld_d = 1'b0;
            addr_d     = BASE_ADDR;
        end else begin
            if (accept_c) begin
                addr_d = addr_q + ADDR_STEP;
                if (new_entry_c.err && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
            case ({pop_c, accept_c})
                2'b10: begin
                    head_d     = tail_q;
                    head_vld_d = tail_vld_q;
                    tail_vld_d = 1'b0;
                end
                2'b01: begin
                    if (!head_vld_q) begin
                        head_d     = new_entry_c;
                        head_vld_d = 1'b1;
                    end else begin
                        tail_d     = new_entry_c;
                        tail_vld_d = 1'b1;
                    end
                end
                2'b11: head_d = new_entry_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            addr_q     <= BASE_ADDR;
            err_cnt_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            addr_q     <= addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.out_valid = head_vld_q;
    assign bus.out_instr = head_q.instr;
    assign bus.out_addr  = head_q.addr;
    assign bus.out_err   = head_q.err;
    assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized
// traffic against a queue-based reference model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic restart;
    always #5 clk = ~clk;

    instr_encoder_if bus();

    instr_encoder dut (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic        err;
        logic [2:0]  t;
        logic [31:0] imm;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q[$];
    logic [31:0] popped[$];
    logic [31:0] m_addr = 32'h0;
    int          m_errc = 0;
    bit          rt_mode = 1'b0;

    // Encoding straight from the format table, range rules in plain integers
    function automatic exp_t model_enc(input logic [2:0] t, input logic [6:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] imm);
        exp_t   e;
        longint s;
        s = longint'($signed(imm));
        e.t = t; e.imm = imm; e.addr = 32'h0;
        case (t)
            3'd0: begin e.word = {f7, rs2, rs1, f3, rd, op}; e.err = 1'b0; end
            3'd1: begin e.word = {imm[11:0], rs1, f3, rd, op};
                        e.err = !(s >= -2048 && s <= 2047); end
            3'd2: begin e.word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                        e.err = !(s >= -2048 && s <= 2047); end
            3'd3: begin e.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                        e.err = !(s >= -4096 && s <= 4094 && imm[0] == 1'b0); end
            3'd4: begin e.word = {imm[31:12], rd, op}; e.err = (imm[11:0] != 12'h0); end
            3'd5: begin e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                        e.err = !(s >= -1048576 && s <= 1048574 && imm[0] == 1'b0); end
            default: begin e.word = 32'h0000_0013; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] w);
        case (t)
            3'd1:    return {{20{w[31]}}, w[31:20]};
            3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    return {w[31:12], 12'h0};
            3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        bus.in_type = instr_type_enum'(t);
        bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
    endtask

    task automatic rand_req(input bit in_range);
        logic [2:0]  t;
        logic [31:0] imm;
        int          k;
        if (in_range) begin
            t = 3'($urandom_range(1, 5));
            case (t)
                3'd1, 3'd2: k = int'($urandom_range(0, 4095)) - 2048;
                3'd3:       k = (int'($urandom_range(0, 4095)) - 2048) * 2;
                3'd5:       k = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                default:    k = int'($urandom() & 32'hFFFF_F000);
            endcase
            imm = k;
        end else begin
            t = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) imm = $urandom();
            else begin k = int'($urandom_range(0, 10000)) - 5000; imm = k; end
        end
        set_req(t, 7'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                3'($urandom()), 7'($urandom()), imm);
    endtask

    // One clock: drive, check against model before the edge, advance model at the edge
    task automatic cycle(input logic v, input logic r, input logic rst, input logic rs);
        exp_t e;
        logic exp_rdy, acc, pop;
        bus.in_valid = v; bus.out_ready = r; reset = rst; restart = rs;
        #1;
        exp_rdy = (q.size() < 2) && !rs && !rst;
        vectors++;
        if (bus.in_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL in_ready: got %b want %b", bus.in_ready, exp_rdy);
        end
        vectors++;
        if (bus.out_valid !== (q.size() != 0)) begin
            miscompares++;
            $display("FAIL out_valid: got %b want %b", bus.out_valid, q.size() != 0);
        end
        vectors++;
        if (bus.err_count !== 16'(m_errc)) begin
            miscompares++;
            $display("FAIL err_count: got %0d want %0d", bus.err_count, m_errc);
        end
        if (q.size() != 0) begin
            vectors++;
            if ({bus.out_instr, bus.out_addr, bus.out_err} !== {q[0].word, q[0].addr, q[0].err}) begin
                miscompares++;
                $display("FAIL head: got instr %h addr %h err %b want instr %h addr %h err %b",
                         bus.out_instr, bus.out_addr, bus.out_err, q[0].word, q[0].addr, q[0].err);
            end
            if (rt_mode && !q[0].err) begin
                vectors++;
                if (extend(q[0].t, bus.out_instr) !== q[0].imm) begin
                    miscompares++;
                    $display("FAIL roundtrip: got imm %h want %h",
                             extend(q[0].t, bus.out_instr), q[0].imm);
                end
            end
        end
        acc = v && exp_rdy;
        pop = (q.size() != 0) && r;
        e = model_enc(3'(bus.in_type), bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                      bus.in_funct3, bus.in_funct7, bus.in_imm);
        @(posedge clk);
        if (rst) begin
            q.delete(); m_addr = BASE_ADDR; m_errc = 0;
        end else if (rs) begin
            q.delete(); m_addr = BASE_ADDR;
        end else begin
            if (pop) begin popped.push_back(q[0].addr); void'(q.pop_front()); end
            if (acc) begin
                e.addr = m_addr; q.push_back(e); m_addr = m_addr + 32'd4;
                if (e.err && m_errc < 65535) m_errc++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_head(input string name, input logic [31:0] instr,
                              input logic [31:0] addr, input logic err);
        vectors++;
        if ({bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err} !== {1'b1, instr, addr, err}) begin
            miscompares++;
            $display("FAIL %s: got v %b instr %h addr %h err %b want v 1 instr %h addr %h err %b",
                     name, bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, instr, addr, err);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; restart = 1'b0; reset = 1'b1;
        set_req(3'd0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, bus.err_count} !== 82'h0) begin
            miscompares++;
            $display("FAIL reset_state: got v %b instr %h addr %h err %b cnt %0d want all 0",
                     bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, bus.err_count);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        do_reset();
        set_req(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("enc_i", 32'h0050_0093, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_req(3'd2, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("enc_s", 32'h0020_A423, 32'h4, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_req(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("enc_b", 32'hFE00_0EE3, 32'h8, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_req(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("enc_j", 32'h0080_00EF, 32'hC, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_req(3'd4, OP_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("enc_u", 32'h1234_51B7, 32'h10, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        do_reset();
        set_req(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("err_i_range", 32'h8000_0093, 32'h0, 1'b1);
        vectors++;
        if (bus.err_count !== 16'd1) begin
            miscompares++; $display("FAIL err_count_1: got %0d want 1", bus.err_count);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_req(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({bus.out_err, bus.err_count} !== {1'b1, 16'd2}) begin
            miscompares++;
            $display("FAIL err_b_odd: got err %b cnt %0d want err 1 cnt 2", bus.out_err, bus.err_count);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_req(3'd7, OP_IMM, 5'd9, 5'd9, 5'd9, 3'd1, 7'd1, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("err_bad_type", 32'h0000_0013, 32'h8, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] want[3];
        want[0] = 32'h0; want[1] = 32'h4; want[2] = 32'h8;
        do_reset();
        popped.delete();
        for (int i = 0; i < 3; i++) begin
            set_req(3'd1, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (popped.size() <= i || popped[i] !== want[i]) begin
                miscompares++;
                $display("FAIL b2b_order[%0d]: got %h want %h", i,
                         (popped.size() > i) ? popped[i] : 32'hX, want[i]);
            end
        end
    endtask

    task automatic test_roundtrip();
        do_reset();
        rt_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_req(1'b1);
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end
        rt_mode = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rand_req(1'b0);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'b0,
                  1'($urandom_range(0, 39) == 0));
        end
    endtask

    task automatic test_restart();
        do_reset();
        set_req(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.err_count} !== {1'b0, 16'd2}) begin
            miscompares++;
            $display("FAIL restart: got v %b cnt %0d want v 0 cnt 2", bus.out_valid, bus.err_count);
        end
        set_req(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("restart_addr", 32'h0031_00B3, 32'h0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        set_req(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_0000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0; bus.in_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.err_count, bus.in_ready, bus.out_instr} !== {1'b0, 16'd0, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid: got v %b cnt %0d rdy %b instr %h want v 0 cnt 0 rdy 1 instr 0",
                     bus.out_valid, bus.err_count, bus.in_ready, bus.out_instr);
        end
        set_req(3'd1, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_head("reset_mid_addr", 32'h0010_0113, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back();
        test_roundtrip();
        test_random();
        test_restart();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
